// File: rtl/scu_pkg.sv
// Shared types and limits for the SCU DMA RAM block.
package scu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } scu_state_e;

  localparam int unsigned CH_MIN  = 1;
  localparam int unsigned CH_MAX  = 8;
  localparam int unsigned LAT_MIN = 1;
  localparam int unsigned LAT_MAX = 8;

  // Wait counter holds at most LAT_MAX-1.
  localparam int unsigned CNT_W = $clog2(LAT_MAX);

  // Number of words carrying a non-zero power-up image.
  localparam int unsigned INIT_WORDS = 4;

  // Power-up image of word idx: nibble (idx+1) replicated, zero beyond INIT_WORDS.
  // Callers truncate to their data width.
  function automatic logic [255:0] init_word(input int unsigned idx);
    logic [3:0] nib;
    nib = 4'(idx + 1);
    return (idx < INIT_WORDS) ? {64{nib}} : '0;
  endfunction

endpackage

// File: rtl/scu_rr_arb.sv
// Round-robin arbiter: search starts at the channel after the last grant.
module scu_rr_arb #(
  parameter int CH = 2,
  parameter int IW = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          en_i,
  input  logic [CH-1:0] req_i,
  output logic [CH-1:0] gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] cand;

  // Pick the first requesting channel at or after the pointer, wrapping.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int i = 0; i < CH; i++) begin
      cand = IW'((int'(ptr_q) + i) % CH);
      if (!valid_o && req_i[cand]) begin
        valid_o     = 1'b1;
        idx_o       = cand;
        gnt_o[cand] = 1'b1;
      end
    end
  end

  // Advance the pointer past the winner only when a grant is actually taken.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else if (en_i && valid_o) begin
      ptr_q <= (idx_o == IW'(CH - 1)) ? '0 : idx_o + 1'b1;
    end
  end

endmodule

// File: rtl/scu_dma_ram.sv
// Multi-channel DMA RAM responder with round-robin arbitration.
// Handshake: a channel holds REQ high with WR/A/DI/BE stable until granted;
// the operands are latched at the grant edge. ACK for that channel is high for
// exactly one CE_R period, and DO is valid while it is high. ACK becomes visible
// after the LAT-th enabled edge counting the grant edge (LAT=1: the cycle after
// the request is seen). A REQ still high when the block is back in IDLE is a
// new request.
module scu_dma_ram
  import scu_pkg::*;
#(
  parameter int DW  = 32,
  parameter int AW  = 4,
  parameter int CH  = 2,
  parameter int LAT = 1
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               CE_R,
  input  logic [CH-1:0]      REQ,
  input  logic [CH-1:0]      WR,
  input  logic [CH*AW-1:0]   A,
  input  logic [CH*DW-1:0]   DI,
  input  logic [CH*DW/8-1:0] BE,
  output logic [DW-1:0]      DO,
  output logic [CH-1:0]      ACK,
  output logic               BUSY,
  output scu_state_e         dbg_state_o
);

  localparam int BW    = DW / 8;
  localparam int DEPTH = 2 ** AW;
  localparam int IW    = (CH > 1) ? $clog2(CH) : 1;

  scu_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [IW-1:0]    ch_q;
  logic             wr_q;
  logic [AW-1:0]    addr_q;
  logic [DW-1:0]    wdata_q;
  logic [BW-1:0]    be_q;
  logic [DW-1:0]    do_q;
  logic [CH-1:0]    ack_q;
  logic             busy_q;

  // Each word is stored XORed with its power-up image, so an all-zero array
  // (the state RAM powers up in) reads back as the required initial contents
  // without any reset-time clearing.
  logic [DW-1:0]    mem_q [DEPTH];

  logic             arb_en;
  logic             gnt_valid;
  logic [CH-1:0]    gnt;
  logic [IW-1:0]    gnt_idx;

  assign arb_en = CE_R && (state_q == ST_IDLE);

  scu_rr_arb #(.CH(CH), .IW(IW)) u_arb (
    .clk_i  (CLK),
    .rst_ni (RST_N),
    .en_i   (arb_en),
    .req_i  (REQ),
    .gnt_o  (gnt),
    .idx_o  (gnt_idx),
    .valid_o(gnt_valid)
  );

  logic          in_wr;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_wdata;
  logic [BW-1:0] in_be;

  assign in_wr    = WR[gnt_idx];
  assign in_addr  = A[int'(gnt_idx) * AW +: AW];
  assign in_wdata = DI[int'(gnt_idx) * DW +: DW];
  assign in_be    = BE[int'(gnt_idx) * BW +: BW];

  logic          acc_go;
  logic          acc_wr;
  logic [AW-1:0] acc_addr;
  logic [DW-1:0] acc_wdata;
  logic [BW-1:0] acc_be;
  logic [DW-1:0] init_pat;

  // Access happens on the grant edge when LAT=1 (live operands), otherwise on
  // the last WAIT edge using the latched operands.
  always_comb begin
    acc_go    = 1'b0;
    acc_wr    = wr_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    acc_be    = be_q;
    if (CE_R) begin
      if (state_q == ST_IDLE && gnt_valid && LAT == 1) begin
        acc_go    = 1'b1;
        acc_wr    = in_wr;
        acc_addr  = in_addr;
        acc_wdata = in_wdata;
        acc_be    = in_be;
      end else if (state_q == ST_WAIT && cnt_q == CNT_W'(1)) begin
        acc_go = 1'b1;
      end
    end
  end

  assign init_pat = DW'(init_word(32'(acc_addr)));

  // Byte-masked write port of the single RAM; no reset so contents survive RST_N.
  always_ff @(posedge CLK) begin
    if (acc_go && acc_wr) begin
      for (int b = 0; b < BW; b++) begin
        if (acc_be[b]) mem_q[acc_addr][b*8 +: 8] <= acc_wdata[b*8 +: 8] ^ init_pat[b*8 +: 8];
      end
    end
  end

  // Access FSM: grant/latch, count wait cycles, strobe ACK, return to IDLE.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ch_q    <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      do_q    <= '0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
    end else if (CE_R) begin
      if (acc_go && !acc_wr) do_q <= mem_q[acc_addr] ^ init_pat;
      unique case (state_q)
        ST_IDLE: begin
          if (gnt_valid) begin
            ch_q    <= gnt_idx;
            wr_q    <= in_wr;
            addr_q  <= in_addr;
            wdata_q <= in_wdata;
            be_q    <= in_be;
            cnt_q   <= CNT_W'(LAT - 1);
            busy_q  <= 1'b1;
            if (LAT == 1) begin
              state_q <= ST_DONE;
              ack_q   <= gnt;
            end else begin
              state_q <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_q == CNT_W'(1)) begin
            state_q <= ST_DONE;
            cnt_q   <= '0;
            ack_q   <= CH'(1) << ch_q;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          ack_q   <= '0;
          busy_q  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign DO          = do_q;
  assign ACK         = ack_q;
  assign BUSY        = busy_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_scu_dma_ram.sv
// Bench for scu_dma_ram: four instances (CH=2, LAT=1..4) sharing clock,
// reset and clock enable, each with its own request inputs.
module tb_scu_dma_ram;
  import scu_pkg::*;

  localparam int ND = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  logic ce;
  always #5 clk = ~clk;

  logic [1:0]  req  [ND];
  logic [1:0]  wr   [ND];
  logic [1:0]  ack  [ND];
  logic [7:0]  a    [ND];
  logic [7:0]  be   [ND];
  logic [63:0] di   [ND];
  logic [31:0] dout [ND];
  logic        busy [ND];
  scu_state_e  st   [ND];

  for (genvar k = 0; k < ND; k++) begin : g_dut
    scu_dma_ram #(.DW(32), .AW(4), .CH(2), .LAT(k + 1)) u_dut (
      .CLK        (clk),
      .RST_N      (rst_n),
      .CE_R       (ce),
      .REQ        (req[k]),
      .WR         (wr[k]),
      .A          (a[k]),
      .DI         (di[k]),
      .BE         (be[k]),
      .DO         (dout[k]),
      .ACK        (ack[k]),
      .BUSY       (busy[k]),
      .dbg_state_o(st[k])
    );
  end

  // ---------------- scoreboard / model ----------------
  logic [31:0] exp_q [$];
  logic [31:0] model_mem [ND][16];
  logic [31:0] model_do  [ND];
  int vec_count  = 0;
  int miss_count = 0;

  typedef struct {
    int          k;
    int          ch;
    bit          w;
    logic [3:0]  ad;
    logic [31:0] d;
    logic [3:0]  bm;
    bit          drop;
    bit          cep;
    logic [31:0] exp_do;
  } vec_t;

  vec_t vt [12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_count++;
    if (act !== exp) begin
      miss_count++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input int k, input int ch, input bit w, input logic [3:0] ad,
                       input logic [31:0] d, input logic [3:0] bm);
    wr[k][ch]          = w;
    a[k][ch*4 +: 4]    = ad;
    di[k][ch*32 +: 32] = d;
    be[k][ch*4 +: 4]   = bm;
  endtask

  task automatic run_access(input int k, input int ch, input bit w, input logic [3:0] ad,
                            input logic [31:0] d, input logic [3:0] bm, input bit drop,
                            input bit cep, input logic [31:0] exp_do);
    int n, c;
    bit got, en;
    logic [1:0]  oh;
    logic [31:0] e;
    oh = 2'b01 << ch;
    exp_q.push_back(exp_do);
    if (w) begin
      for (int b = 0; b < 4; b++) begin
        if (bm[b]) model_mem[k][ad][b*8 +: 8] = d[b*8 +: 8];
      end
    end
    drive(k, ch, w, ad, d, bm);
    req[k][ch] = 1'b1;
    n = 0; c = 0; got = 1'b0;
    while (!got && c < 40) begin
      if (cep) ce = (c % 3 == 0);
      en = ce;
      tick();
      c++;
      if (en) n++;
      if (drop) req[k][ch] = 1'b0;
      if (ack[k] != 2'b00) got = 1'b1;
    end
    req[k][ch] = 1'b0;
    chk("latency", n, k + 1);
    chk("ack_onehot", ack[k], oh);
    e = exp_q.pop_front();
    chk("read_data", dout[k], e);
    ce = 1'b0;
    tick();
    chk("ack_freeze", {ack[k], dout[k]}, {oh, e});
    ce = 1'b1;
    tick();
    chk("ack_clear", {busy[k], ack[k]}, 3'b000);
    if (!w) model_do[k] = model_mem[k][ad];
  endtask

  // Both channels of instance 0 (LAT=1) request continuously; grants must
  // alternate starting at channel 0.
  task automatic rr_run(input int ngr);
    int seen, c;
    bit both;
    logic [31:0] e;
    drive(0, 0, 1'b0, 4'd0, 32'h0, 4'h0);
    drive(0, 1, 1'b0, 4'd1, 32'h0, 4'h0);
    for (int i = 0; i < ngr; i++) exp_q.push_back((i % 2 == 0) ? 32'h11111111 : 32'h22222222);
    req[0] = 2'b11;
    seen = 0; c = 0; both = 1'b0;
    while (seen < ngr && c < 40) begin
      tick();
      c++;
      if (ack[0] == 2'b11) both = 1'b1;
      if (ack[0] != 2'b00) begin
        chk("rr_grant", ack[0], (seen % 2 == 0) ? 2'b01 : 2'b10);
        e = exp_q.pop_front();
        chk("rr_data", dout[0], e);
        seen++;
      end
    end
    req[0] = 2'b00;
    chk("rr_count", seen, ngr);
    tick();
    chk("rr_never_both", both, 1'b0);
    exp_q.delete();
    model_do[0] = (ngr % 2 == 1) ? 32'h11111111 : 32'h22222222;
  endtask

  task automatic random_phase(input int count);
    bit          w;
    int          ch;
    logic [3:0]  ad, bm;
    logic [31:0] d, e;
    for (int i = 0; i < count; i++) begin
      w  = 1'($urandom_range(0, 1));
      ch = $urandom_range(0, 1);
      ad = 4'($urandom_range(0, 15));
      bm = 4'($urandom_range(0, 15));
      d  = $urandom;
      e  = w ? model_do[1] : model_mem[1][ad];
      run_access(1, ch, w, ad, d, bm, 1'b0, 1'b0, e);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0;
    ce    = 1'b1;
    for (int k = 0; k < ND; k++) begin
      req[k] = '0; wr[k] = '0; a[k] = '0; be[k] = '0; di[k] = '0;
      model_do[k] = '0;
      for (int i = 0; i < 16; i++) model_mem[k][i] = (i < 4) ? {8{4'(i + 1)}} : 32'h0;
    end

    //        k  ch w  ad     data          be    drop cep exp DO
    vt[0]  = '{0, 0, 0, 4'd2,  32'h0,        4'h0, 0,   0,  32'h33333333};
    vt[1]  = '{0, 1, 0, 4'd0,  32'h0,        4'h0, 0,   0,  32'h11111111};
    vt[2]  = '{0, 0, 1, 4'd15, 32'hDEADBEEF, 4'h8, 0,   0,  32'h11111111};
    vt[3]  = '{0, 1, 0, 4'd15, 32'h0,        4'h0, 0,   0,  32'hDE000000};
    vt[4]  = '{2, 1, 1, 4'd5,  32'hAABBCCDD, 4'h5, 0,   0,  32'h00000000};
    vt[5]  = '{2, 0, 0, 4'd5,  32'h0,        4'h0, 0,   0,  32'h00BB00DD};
    vt[6]  = '{1, 0, 1, 4'd7,  32'h12345678, 4'hF, 0,   0,  32'h00000000};
    vt[7]  = '{1, 1, 0, 4'd7,  32'h0,        4'h0, 0,   0,  32'h12345678};
    vt[8]  = '{1, 0, 0, 4'd1,  32'h0,        4'h0, 1,   0,  32'h22222222};
    vt[9]  = '{1, 0, 0, 4'd3,  32'h0,        4'h0, 0,   1,  32'h44444444};
    vt[10] = '{3, 1, 1, 4'd3,  32'hFFFFFFFF, 4'h0, 0,   0,  32'h00000000};
    vt[11] = '{3, 0, 0, 4'd3,  32'h0,        4'h0, 0,   0,  32'h44444444};

    tick();
    tick();
    for (int k = 0; k < ND; k++) begin
      chk("rst_do", dout[k], 32'h0);
      chk("rst_ack", ack[k], 2'b00);
      chk("rst_busy", busy[k], 1'b0);
      chk("rst_state", st[k], ST_IDLE);
    end
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 12; i++) begin
      run_access(vt[i].k, vt[i].ch, vt[i].w, vt[i].ad, vt[i].d, vt[i].bm,
                 vt[i].drop, vt[i].cep, vt[i].exp_do);
    end

    // Three grants leave the round-robin pointer on channel 1.
    rr_run(3);

    // Reset two edges into a LAT=4 write to word 0: no ACK, no memory update.
    drive(3, 0, 1'b1, 4'd0, 32'h0, 4'hF);
    req[3][0] = 1'b1;
    tick();
    tick();
    chk("busy_mid_access", busy[3], 1'b1);
    rst_n = 1'b0;
    #2;
    chk("rst_abort_busy", busy[3], 1'b0);
    chk("rst_abort_ack", ack[3], 2'b00);
    chk("rst_abort_do", dout[3], 32'h0);
    req[3][0] = 1'b0;
    tick();
    chk("rst_abort_no_ack", ack[3], 2'b00);
    rst_n = 1'b1;
    for (int k = 0; k < ND; k++) model_do[k] = '0;
    tick();

    // Pointer must restart at channel 0 after reset.
    rr_run(2);
    run_access(3, 0, 1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h11111111);
    run_access(0, 1, 1'b0, 4'd15, 32'h0, 4'h0, 1'b0, 1'b0, 32'hDE000000);

    random_phase(12);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule

// File: doc/scu_dma_ram.md
SCU_DMA_RAM -- requirements
Module: scu_dma_ram

Interface
REQ-001 SHALL have parameter DW, default 32, data width in bits; multiple of 8.
REQ-002 SHALL have parameter AW, default 4, word-address width; depth = 2**AW words.
REQ-003 SHALL have parameter CH, default 2, number of requester channels (1..8).
REQ-004 SHALL have parameter LAT, default 1, CE_R cycles from grant to ACK (1..8).
REQ-005 SHALL have port CLK  in  1  clock.
REQ-006 SHALL have port RST_N  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port CE_R  in  1  clock enable; all state advances only on CLK edges with CE_R=1.
REQ-008 SHALL have port REQ  in  CH  per-channel access request, level.
REQ-009 SHALL have port WR  in  CH  per-channel direction, 1=write, 0=read.
REQ-010 SHALL have port A  in  CH*AW  per-channel word address, channel n at [n*AW +: AW].
REQ-011 SHALL have port DI  in  CH*DW  per-channel write data.
REQ-012 SHALL have port BE  in  CH*DW/8  per-channel byte enables, write only.
REQ-013 SHALL have port DO  out  DW  read data, shared, valid while the granted channel's ACK=1.
REQ-014 SHALL have port ACK  out  CH  per-channel completion strobe.
REQ-015 SHALL have port BUSY  out  1  access in progress (state not IDLE).

Function
REQ-016 SHALL implement states IDLE, WAIT, DONE.
REQ-017 IDLE: on CE_R with any REQ=1, SHALL grant one channel round-robin, starting at the channel after the last granted (channel 0 first after reset).
REQ-018 On grant SHALL latch channel index, WR, A, DI, BE; load wait counter with LAT-1; go to WAIT, or to DONE directly if LAT=1.
REQ-019 WAIT: SHALL decrement counter each CE_R; at counter 0 perform access and go to DONE.
REQ-020 Access: read SHALL register MEM[addr] into DO; write SHALL update only bytes with BE=1; DO unchanged on write.
REQ-021 DONE: ACK[granted]=1 for exactly one CE_R period; all other ACK bits 0; next CE_R returns to IDLE.
REQ-022 Total latency: grant edge to ACK rising = LAT CE_R edges; LAT=1 matches single-cycle responder timing.
REQ-023 Requester SHALL drop REQ during its ACK period; REQ still high at the IDLE edge after DONE is a new request.
REQ-024 REQ deasserted after grant: latched access still completes and ACKs.
REQ-025 Simultaneous REQ on all channels: each served once per CH grants, none starved.
REQ-026 Addresses use AW bits only; no out-of-range condition exists.
REQ-027 DO SHALL hold last read value until next read completes.
REQ-028 CE_R=0 SHALL freeze state, counter, DO, ACK.
REQ-029 BE all zero on write: access and ACK occur, memory unchanged.

Reset
REQ-030 RST_N=0 SHALL force state IDLE, DO=0, ACK=0, BUSY=0, counter=0, round-robin pointer to channel 0.
REQ-031 Reset mid-access SHALL abort without ACK; a pending write not yet performed SHALL NOT reach memory.
REQ-032 Memory contents SHALL NOT be cleared by reset; power-up contents: word0..3 = 11111111, 22222222, 33333333, 44444444 (hex, DW=32), rest 0.

Structure
REQ-033 State enum and LAT/CH limit constants SHALL live in SCU_PKG.
REQ-034 Round-robin arbiter SHALL be one sub-module, scu_rr_arb (inputs REQ, enable; outputs one-hot grant, index).
REQ-035 Memory SHALL be a single inferred RAM, one port, one access per grant.

Verification
REQ-036 LAT=1, CH=1: read A=2 -> ACK 1 CE_R later, DO=33333333.
REQ-037 LAT=3: write A=5, DI=AABBCCDD, BE=0101b, then read A=5 -> ACK 3 CE_R after each grant, DO=00BB00DD.
REQ-038 CH=2, REQ=11 held with immediate re-request -> grants alternate 0,1,0,1; ACK never on both.
REQ-039 LAT=4, RST_N low 2 CE_R after write grant to A=0 -> no ACK; read A=0 returns 11111111.
REQ-040 CE_R toggled 1-in-3 during LAT=2 read of A=3 -> ACK after 2 enabled edges, DO=44444444.
REQ-041 REQ dropped one cycle after grant, read A=1 -> ACK still asserted, DO=22222222.
